// File: rtl/hazard_controller.sv
// Hazard controller for the no-forwarding 5-stage MIPS-lite core.
// Stalls ID on RAW hazards, flushes on taken branches, drains on HALT.
module hazard_controller #(
    parameter int REGISTERWIDTH = 5,
    parameter int CNTW          = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REGISTERWIDTH-1:0] id_rs,
    input  logic [REGISTERWIDTH-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic [REGISTERWIDTH-1:0] id_rd,
    input  logic                     id_writes_rd,
    input  logic                     id_halt,
    input  logic                     ex_branch_taken,
    output logic                     pc_write_en,
    output logic                     ifid_write_en,
    output logic                     ifid_flush,
    output logic                     idex_bubble,
    output logic                     halted,
    output logic [CNTW-1:0]          stall_cycles,
    output logic [CNTW-1:0]          flush_events
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [1:0]               r_drain_cnt;
    logic [1:0]               w_next_drain_cnt;
    logic                     r_ex_vld;
    logic [REGISTERWIDTH-1:0] r_ex_rd;
    logic                     r_mem_vld;
    logic [REGISTERWIDTH-1:0] r_mem_rd;
    logic [CNTW-1:0]          r_stall_cnt;
    logic [CNTW-1:0]          r_flush_cnt;
    logic                     w_rs_hit;
    logic                     w_rt_hit;
    logic                     w_hazard;
    logic                     w_stall_inc;
    logic                     w_flush_inc;

    // Index 0 is hardwired zero and can never carry a dependency.
    assign w_rs_hit = id_uses_rs && (id_rs != '0) &&
                      ((r_ex_vld && r_ex_rd == id_rs) ||
                       (r_mem_vld && r_mem_rd == id_rs));
    assign w_rt_hit = id_uses_rt && (id_rt != '0) &&
                      ((r_ex_vld && r_ex_rd == id_rt) ||
                       (r_mem_vld && r_mem_rd == id_rt));
    assign w_hazard = id_valid && (w_rs_hit || w_rt_hit);

    always_comb begin
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;
        pc_write_en      = 1'b0;
        ifid_write_en    = 1'b0;
        ifid_flush       = 1'b0;
        idex_bubble      = 1'b1;
        halted           = 1'b0;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        if (!rst_n) begin
            ifid_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        ifid_flush    = 1'b1;
                        w_flush_inc   = 1'b1;
                    end else if (w_hazard) begin
                        w_stall_inc = 1'b1;
                    end else if (id_halt && id_valid) begin
                        ifid_write_en    = 1'b1;
                        ifid_flush       = 1'b1;
                        idex_bubble      = 1'b0;
                        w_next_state     = DRAIN;
                        w_next_drain_cnt = 2'd3;
                    end else begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        idex_bubble   = 1'b0;
                    end
                end
                DRAIN: begin
                    w_next_drain_cnt = r_drain_cnt - 2'd1;
                    if (r_drain_cnt == 2'd1) begin
                        w_next_state = HALTED;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_cnt <= 2'd0;
            r_ex_vld    <= 1'b0;
            r_ex_rd     <= '0;
            r_mem_vld   <= 1'b0;
            r_mem_rd    <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain_cnt;
            r_mem_vld   <= r_ex_vld;
            r_mem_rd    <= r_ex_rd;
            r_ex_vld    <= id_valid && id_writes_rd &&
                           (id_rd != '0) && !idex_bubble;
            r_ex_rd     <= id_rd;
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: stalls, flushes, halt drain, reset.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_rd;
    logic        id_writes_rd;
    logic        id_halt;
    logic        ex_branch_taken;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    int checks   = 0;
    int failures = 0;

    hazard_controller #(.REGISTERWIDTH(5), .CNTW(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_rd           (id_rd),
        .id_writes_rd    (id_writes_rd),
        .id_halt         (id_halt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write_en     (pc_write_en),
        .ifid_write_en   (ifid_write_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd,
                         input logic wrd, input logic h, input logic br);
        id_valid        = v;
        id_rs           = rs;
        id_uses_rs      = urs;
        id_rt           = rt;
        id_uses_rt      = urt;
        id_rd           = rd;
        id_writes_rd    = wrd;
        id_halt         = h;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sample control outputs mid-cycle, then advance to the next cycle.
    task automatic cyc(input string tag, input logic pc, input logic ifw,
                       input logic fl, input logic chk_fl,
                       input logic bub, input logic hlt);
        @(negedge clk);
        chk({tag, ".pc"},  {31'd0, pc_write_en},   {31'd0, pc});
        chk({tag, ".ifw"}, {31'd0, ifid_write_en}, {31'd0, ifw});
        if (chk_fl) chk({tag, ".fl"}, {31'd0, ifid_flush}, {31'd0, fl});
        chk({tag, ".bub"}, {31'd0, idex_bubble},   {31'd0, bub});
        chk({tag, ".hlt"}, {31'd0, halted},        {31'd0, hlt});
        @(posedge clk);
        #1;
    endtask

    task automatic run_ok(input string tag);
        cyc(tag, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic stall(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain(input string tag, input logic hlt);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hlt);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst.pc",  {31'd0, pc_write_en},   32'd0);
        chk("rst.ifw", {31'd0, ifid_write_en}, 32'd0);
        chk("rst.fl",  {31'd0, ifid_flush},    32'd1);
        chk("rst.bub", {31'd0, idex_bubble},   32'd1);
        chk("rst.hlt", {31'd0, halted},        32'd0);
        chk("rst.stall", stall_cycles, 32'd0);
        chk("rst.flush", flush_events, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add r3,r1,r2 ; sub r4,r3,r5 back-to-back
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        run_ok("d1.add");
        drive(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        stall("d1.s1");
        stall("d1.s2");
        run_ok("d1.go");
        chk("d1.stall", stall_cycles, 32'd2);
        idle();
        run_ok("n1");
        run_ok("n2");

        // distance 2: one stall
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        run_ok("d2.prod");
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        run_ok("d2.ind");
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        stall("d2.s1");
        run_ok("d2.go");
        chk("d2.stall", stall_cycles, 32'd3);

        // distance 3: no stall
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        run_ok("d3.prod");
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        run_ok("d3.i1");
        run_ok("d3.i2");
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        run_ok("d3.cons");
        chk("d3.stall", stall_cycles, 32'd3);

        // r0 never hazards; unused rt never hazards
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        run_ok("r0.prod");
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
        run_ok("r0.cons");
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        run_ok("rt.prod");
        drive(1'b1, 5'd1, 1'b1, 5'd8, 1'b0, 5'd13, 1'b0, 1'b0, 1'b0);
        run_ok("rt.cons");
        chk("r0.stall", stall_cycles, 32'd3);
        idle();
        run_ok("n3");
        run_ok("n4");

        // taken branch beats hazard
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        run_ok("br.prod");
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1);
        cyc("br.flush", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("br.stall", stall_cycles, 32'd3);
        chk("br.fev", flush_events, 32'd1);
        idle();
        run_ok("n5");
        run_ok("n6");

        // HALT: drain three cycles, branch during drain ignored
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("h.acc", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        drain("h.d1", 1'b0);
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        drain("h.d2", 1'b0);
        idle();
        drain("h.d3", 1'b0);
        drain("h.h1", 1'b1);
        drain("h.h2", 1'b1);
        chk("h.fev", flush_events, 32'd1);
        chk("h.stall", stall_cycles, 32'd3);

        // reset mid-drain with nonzero counters
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        run_ok("r2.prod");
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        cyc("r2.br", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("r2.hacc", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        drain("r2.d1", 1'b0);
        chk("r2.fev", flush_events, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r2.pc",  {31'd0, pc_write_en},   32'd0);
        chk("r2.ifw", {31'd0, ifid_write_en}, 32'd0);
        chk("r2.fl",  {31'd0, ifid_flush},    32'd1);
        chk("r2.bub", {31'd0, idex_bubble},   32'd1);
        chk("r2.hlt", {31'd0, halted},        32'd0);
        chk("r2.fcnt", flush_events, 32'd0);
        chk("r2.scnt", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        run_ok("r2.run");
        run_ok("r2.run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS-lite core in its no-forwarding configuration. It tracks destination registers of instructions in flight in EX and MEM, stalls the ID stage on read-after-write hazards, flushes wrong-path instructions when the execution stage reports a taken branch or jump, and drains the pipeline to a halted state on HALT. It drives the PC, IF/ID and ID/EX register controls and keeps stall and flush counters.

## Interface
- REGISTERWIDTH, 5, register-index width
- CNTW, 32, performance-counter width
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real (non-bubble) instruction
- id_rs, id_rt  in  REGISTERWIDTH  source register indices of ID instruction
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_rd  in  REGISTERWIDTH  destination index of ID instruction
- id_writes_rd  in  1  ID instruction writes the register file
- id_halt  in  1  ID instruction is HALT
- ex_branch_taken  in  1  branchTaken from the execution stage (instruction now in EX redirects PC)
- pc_write_en  out  1  PC register load enable
- ifid_write_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_bubble  out  1  ID/EX loads a bubble instead of the ID instruction
- halted  out  1  pipeline fully drained after HALT
- stall_cycles  out  CNTW  count of hazard-stall cycles
- flush_events  out  CNTW  count of taken-branch flushes

## Operation
- Scoreboard: two registered slots, ex_slot and mem_slot, each {valid, rd}. Every clock: mem_slot <= ex_slot; ex_slot <= {id_valid & id_writes_rd & id_rd!=0 & ~idex_bubble, id_rd}.
- Register file writes in the first half cycle, so a producer in WB is never a hazard.
- hazard = id_valid & ((id_uses_rs & id_rs!=0 & match(id_rs)) | (id_uses_rt & id_rt!=0 & match(id_rt))), match(r) = (ex_slot.valid & ex_slot.rd==r) | (mem_slot.valid & mem_slot.rd==r).
- FSM states RUN, DRAIN, HALTED.
- RUN, priority order:
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write_en=1 (loads newAddress), ifid_write_en=1; hazard and id_halt ignored; flush_events++.
  - hazard: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0; stall_cycles++.
  - id_halt & id_valid: HALT passes to EX (idex_bubble=0); pc_write_en=0, ifid_flush=1; next state DRAIN, drain counter=3.
  - otherwise: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0.
- DRAIN: pc_write_en=0, ifid_write_en=0, idex_bubble=1; ex_branch_taken ignored (HALT cannot branch); counter decrements each cycle; at counter==1 next state HALTED.
- HALTED: same outputs as DRAIN, halted=1; exit only by reset.
- Counters saturate at all-ones; never wrap.
- rd==0 never enters the scoreboard; index 0 never matches.

## Timing
- Control outputs combinational from current state, scoreboard and ID/EX inputs; scoreboard, FSM, counters registered on rising clk.
- RAW distance 1 (producer in EX): 2 stall cycles. Distance 2 (producer in MEM): 1 stall cycle. Distance >=3: none.
- Taken branch: exactly 2 wrong-path instructions killed (one in ID via idex_bubble, one in IF via ifid_flush); 2-cycle penalty.
- HALT accepted at cycle t: DRAIN t+1..t+3, halted=1 from t+4 (HALT has left WB).
- Reset (rst_n low, any cycle including mid-stall or mid-drain): state RUN, slots invalid, counters 0, halted=0; while low pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_bubble=1. First cycle after deassert: normal RUN outputs.

## Test plan
- add r3,r1,r2 then sub r4,r3,r5 back-to-back -> pc_write_en=0 and idex_bubble=1 for exactly 2 cycles, stall_cycles=2; sub enters EX on cycle 3.
- Producer r3, one independent instruction, consumer of r3 -> 1 stall cycle; distance 3 -> 0 stalls.
- Producer writes r0, consumer reads r0 -> no stall; id_uses_rt=0 with id_rt matching -> no stall.
- ex_branch_taken=1 while ID holds a hazarding instruction -> ifid_flush=1, idex_bubble=1, pc_write_en=1, stall_cycles unchanged, flush_events=1.
- HALT in ID at cycle 10 with no hazard -> pc_write_en=0 from cycle 10, halted=1 at cycle 14 and held; ex_branch_taken pulse at cycle 12 has no effect.
- rst_n low at cycle 12 during DRAIN, counters nonzero -> all outputs at reset values immediately, counters 0, after release state RUN and pc_write_en=1.
